aes_key_sched: RTL



---
 rtl/aes_pkg.sv | 37 +++
 rtl/aes_sbox.sv | 17 +
 rtl/aes_key_sched.sv | 80 ++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES constants, FSM state encoding and GF(2^8) helper functions
package aes_pkg;
    localparam int NR = 10;
    localparam int KW = 128;

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY} state_t;

    // Index 0 and 11..15 are never used; the padding lets a 4-bit counter index it directly
    localparam logic [7:0] RCON [16] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                                         8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    function automatic logic [7:0] gf_mul2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = gf_mul2(x);
        end
        return p;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [31:0] r;
        for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
        for (int i = 0; i < 4; i++)
            r[31-8*i -: 8] = gf_mul(a[i], 8'h0e) ^ gf_mul(a[(i+1)%4], 8'h0b) ^
                             gf_mul(a[(i+2)%4], 8'h0d) ^ gf_mul(a[(i+3)%4], 8'h09);
        return r;
    endfunction
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box (GF(2^8) inverse followed by the affine transform)
module aes_sbox import aes_pkg::*; (
    input  logic [7:0] x,
    output logic [7:0] y
);
    logic [7:0] p [8];
    logic [7:0] inv;

    // Inverse as x^254 = x^2 * x^4 * ... * x^128 (zero maps to zero), then affine map
    always_comb begin
        p[0] = x;
        for (int i = 1; i < 8; i++) p[i] = gf_mul(p[i-1], p[i-1]);
        inv = p[1];
        for (int i = 2; i < 8; i++) inv = gf_mul(inv, p[i]);
        y = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

// File: rtl/aes_key_sched.sv
// aes_key_sched: iterative AES-128 key expansion into an 11-entry round-key file with a registered indexed read port.
// Optional feature macro AES_KEYSCHED_EQINV_EN adds rd_inv for InvMixColumns'd (equivalent inverse cipher) keys.
module aes_key_sched import aes_pkg::*; (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] key,
    output logic          busy,
    output logic          done,
    output logic          key_valid,
    input  logic [3:0]    rd_idx,
    input  logic          rd_dec,
`ifdef AES_KEYSCHED_EQINV_EN
    input  logic          rd_inv,
`endif
    output logic [KW-1:0] rk_out
);
    state_t state, state_nxt;
    logic [3:0] cnt;
    logic [KW-1:0] rk [NR+1];
    logic [KW-1:0] prev, rd_key;
    logic [31:0] rot, sub, temp, w0, w1, w2, w3;
    logic [3:0] p;
    logic expand, last;

    assign expand = state == S_EXPAND;
    assign last = expand && cnt == 4'(NR);
    assign busy = expand;
    assign key_valid = state == S_READY;

    assign prev = rk[cnt - 4'd1];
    assign rot = {prev[23:0], prev[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.x(rot[8*i +: 8]), .y(sub[8*i +: 8]));
    end

    assign temp = sub ^ {RCON[cnt], 24'h0};
    assign w0 = prev[127:96] ^ temp;
    assign w1 = prev[95:64] ^ w0;
    assign w2 = prev[63:32] ^ w1;
    assign w3 = prev[31:0] ^ w2;

    assign p = rd_dec ? 4'(NR) - rd_idx : rd_idx;

`ifdef AES_KEYSCHED_EQINV_EN
    logic [KW-1:0] rd_raw;
    assign rd_raw = rk[p];
    assign rd_key = (rd_inv && rd_dec && p >= 4'd1 && p <= 4'd9) ?
                    {inv_mix_col(rd_raw[127:96]), inv_mix_col(rd_raw[95:64]),
                     inv_mix_col(rd_raw[63:32]), inv_mix_col(rd_raw[31:0])} : rd_raw;
`else
    assign rd_key = rk[p];
`endif

    // State register
    always_ff @(posedge clk) state <= rst ? S_IDLE : state_nxt;

    // Next state: start accepted outside EXPAND; EXPAND runs until round key 10 is written
    always_comb state_nxt = expand ? (last ? S_READY : S_EXPAND) : (start ? S_EXPAND : state);

    // Round counter, done pulse and registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            done <= 1'b0;
            rk_out <= '0;
        end else begin
            cnt <= expand ? (last ? 4'd0 : cnt + 4'd1) : (start ? 4'd1 : cnt);
            done <= last;
            rk_out <= (!key_valid || rd_idx > 4'(NR)) ? '0 : rd_key;
        end
    end

    // Round-key file: cipher key on an accepted start, one expanded key per EXPAND cycle
    always_ff @(posedge clk) begin
        if (!rst && !expand && start) rk[0] <= key;
        else if (!rst && expand) rk[cnt] <= {w0, w1, w2, w3};
    end
endmodule
